swap_counter_pair: RTL and testbench

- Parametrised successor to the 4-bit up/down swap counter pair: two WIDTH-bit registers, one counting up and one counting down, with a programmable step, wrap or saturate mode, parallel load, swap and registered wrap-event flags.
- Asynchronous active-low reset gives defined start values.
- Used as a pair of event/timer counters in the exercise datapaths. The equality flag is an optional build feature.

---
 rtl/swap_counter_pkg.sv | 32 +++
 rtl/swap_counter_pair_sat_step.sv | 42 ++++
 rtl/swap_counter_pair.sv | 126 ++++++++++++
 tb/tb_swap_counter_pair.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/swap_counter_pkg.sv
// ============================================================================
// Module : swap_counter_pkg
// Brief  : Shared operation encoding and decode for swap_counter_pair.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package swap_counter_pkg;

  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_COUNT = 2'd1,
    OP_SWAP  = 2'd2,
    OP_LOAD  = 2'd3
  } op_e;

  localparam logic c_DIR_UP   = 1'b0;
  localparam logic c_DIR_DOWN = 1'b1;

  // Fixed priority: load beats swap beats count; load ignores enable.
  function automatic op_e op_select(input logic load, input logic enable, input logic swap);
    op_e op;
    if (load)                op = OP_LOAD;
    else if (enable && swap) op = OP_SWAP;
    else if (enable)         op = OP_COUNT;
    else                     op = OP_HOLD;
    return op;
  endfunction

endpackage

`default_nettype wire

// File: rtl/swap_counter_pair_sat_step.sv
// ============================================================================
// Module : sat_step
// Brief  : Combinational add/sub of a step with wrap or saturate behaviour.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_step
  import swap_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] operand,
  input  logic [WIDTH-1:0] step,
  input  logic             dir,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] result,
  output logic             evt
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_unf;

  always_comb begin
    w_sum  = {1'b0, operand} + {1'b0, step};
    w_diff = operand - step;
    w_unf  = (step > operand);
    result = operand;
    evt    = 1'b0;
    if (dir == c_DIR_UP) begin
      evt    = w_sum[WIDTH];
      result = (sat_mode && w_sum[WIDTH]) ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
    end else begin
      evt    = w_unf;
      result = (sat_mode && w_unf) ? {WIDTH{1'b0}} : w_diff;
    end
  end

endmodule

`default_nettype wire

// File: rtl/swap_counter_pair.sv
// ============================================================================
// Module : swap_counter_pair
// Brief  : Up/down counter pair with step, wrap/saturate, load, swap and
//          registered wrap flags. Define SWAP_COUNTER_EQ_EN for the equal port.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module swap_counter_pair
  import swap_counter_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] UP_INIT   = '0,
  parameter logic [WIDTH-1:0] DOWN_INIT = '1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_up,
  input  logic [WIDTH-1:0] load_down,
  input  logic             swap,
  input  logic [WIDTH-1:0] step,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] upCount,
  output logic [WIDTH-1:0] downCount,
  output logic             up_wrap,
  output logic             down_wrap
`ifdef SWAP_COUNTER_EQ_EN
  ,
  output logic             equal
`endif
);

  logic [WIDTH-1:0] r_up;
  logic [WIDTH-1:0] r_down;
  logic             r_up_wrap;
  logic             r_down_wrap;

  op_e              w_op;
  logic [WIDTH-1:0] w_up_res;
  logic [WIDTH-1:0] w_down_res;
  logic             w_up_evt;
  logic             w_down_evt;
  logic [WIDTH-1:0] w_up_next;
  logic [WIDTH-1:0] w_down_next;
  logic             w_up_wrap_next;
  logic             w_down_wrap_next;

  sat_step #(.WIDTH(WIDTH)) u_up_step (
    .operand  (r_up),
    .step     (step),
    .dir      (c_DIR_UP),
    .sat_mode (sat_mode),
    .result   (w_up_res),
    .evt      (w_up_evt)
  );

  sat_step #(.WIDTH(WIDTH)) u_down_step (
    .operand  (r_down),
    .step     (step),
    .dir      (c_DIR_DOWN),
    .sat_mode (sat_mode),
    .result   (w_down_res),
    .evt      (w_down_evt)
  );

  always_comb begin
    w_op             = op_select(load, enable, swap);
    w_up_next        = r_up;
    w_down_next      = r_down;
    w_up_wrap_next   = 1'b0;
    w_down_wrap_next = 1'b0;
    case (w_op)
      OP_LOAD: begin
        w_up_next   = load_up;
        w_down_next = load_down;
      end
      OP_SWAP: begin
        w_up_next   = r_down;
        w_down_next = r_up;
      end
      OP_COUNT: begin
        w_up_next        = w_up_res;
        w_down_next      = w_down_res;
        w_up_wrap_next   = w_up_evt;
        w_down_wrap_next = w_down_evt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_up        <= UP_INIT;
      r_down      <= DOWN_INIT;
      r_up_wrap   <= 1'b0;
      r_down_wrap <= 1'b0;
    end else begin
      r_up        <= w_up_next;
      r_down      <= w_down_next;
      r_up_wrap   <= w_up_wrap_next;
      r_down_wrap <= w_down_wrap_next;
    end
  end

  assign upCount   = r_up;
  assign downCount = r_down;
  assign up_wrap   = r_up_wrap;
  assign down_wrap = r_down_wrap;

`ifdef SWAP_COUNTER_EQ_EN
  // Compared on next-state values so the flag lines up with the new counts.
  logic r_equal;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_equal <= (UP_INIT == DOWN_INIT);
    else          r_equal <= (w_up_next == w_down_next);
  end

  assign equal = r_equal;
`endif

endmodule

`default_nettype wire

// File: tb/tb_swap_counter_pair.sv
// ============================================================================
// Module : tb_swap_counter_pair
// Brief  : Scoreboard bench for swap_counter_pair with WIDTH=4 defaults.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_swap_counter_pair;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_up = '0;
  logic [3:0] load_down = '0;
  logic       swap = 1'b0;
  logic [3:0] step = '0;
  logic       sat_mode = 1'b0;
  logic [3:0] upCount;
  logic [3:0] downCount;
  logic       up_wrap;
  logic       down_wrap;
`ifdef SWAP_COUNTER_EQ_EN
  logic       equal;
`endif

  swap_counter_pair dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .enable    (enable),
    .load      (load),
    .load_up   (load_up),
    .load_down (load_down),
    .swap      (swap),
    .step      (step),
    .sat_mode  (sat_mode),
    .upCount   (upCount),
    .downCount (downCount),
    .up_wrap   (up_wrap),
    .down_wrap (down_wrap)
`ifdef SWAP_COUNTER_EQ_EN
    ,
    .equal     (equal)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    int         cyc;
    logic [3:0] up;
    logic [3:0] dn;
    logic       uw;
    logic       dw;
    logic       eq;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic dut_eq(input logic [3:0] up, input logic [3:0] dn);
`ifdef SWAP_COUNTER_EQ_EN
    return equal;
`else
    return (up == dn);
`endif
  endfunction

  task automatic check(input string name, input exp_t e);
    logic act_eq;
    act_eq = dut_eq(upCount, downCount);
    n_checks++;
    if (upCount !== e.up || downCount !== e.dn || up_wrap !== e.uw ||
        down_wrap !== e.dw || act_eq !== e.eq) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got up=%0d dn=%0d uw=%b dw=%b eq=%b, expected up=%0d dn=%0d uw=%b dw=%b eq=%b",
               name, cyc, upCount, downCount, up_wrap, down_wrap, act_eq,
               e.up, e.dn, e.uw, e.dw, e.eq);
    end
  endtask

  // Monitor: outputs are presented every cycle, so each queued entry is due on a given cycle.
  always @(negedge clock) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      if (e.cyc != cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL sched: entry for cycle %0d seen at cycle %0d", e.cyc, cyc);
      end else begin
        check("scoreboard", e);
      end
    end
  end

  task automatic drive(input logic ld, input logic [3:0] lu, input logic [3:0] ldn,
                       input logic en, input logic sw, input logic [3:0] st, input logic sm,
                       input logic [3:0] eu, input logic [3:0] ed,
                       input logic euw, input logic edw);
    exp_t e;
    @(negedge clock);
    #1;
    load = ld; load_up = lu; load_down = ldn;
    enable = en; swap = sw; step = st; sat_mode = sm;
    e.cyc = cyc + 1;
    e.up = eu; e.dn = ed; e.uw = euw; e.dw = edw; e.eq = (eu == ed);
    q.push_back(e);
  endtask

  task automatic direct(input string name, input logic [3:0] eu, input logic [3:0] ed);
    exp_t e;
    e.cyc = cyc; e.up = eu; e.dn = ed; e.uw = 1'b0; e.dw = 1'b0; e.eq = (eu == ed);
    check(name, e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clock);
    #1 direct("reset_state", 4'd0, 4'd15);
    @(negedge clock);
    #1 reset_n = 1'b1;
    direct("after_release", 4'd0, 4'd15);

    // basic count, step 1
    drive(0, 0, 0, 1, 0, 1, 0, 4'd1, 4'd14, 0, 0);
    drive(0, 0, 0, 1, 0, 1, 0, 4'd2, 4'd13, 0, 0);
    drive(0, 0, 0, 1, 0, 1, 0, 4'd3, 4'd12, 0, 0);

    // wrap mode: 14+3 -> 1 (ovf), 1-3 -> 14 (unf); flags last one cycle
    drive(1, 14, 1, 0, 0, 3, 0, 4'd14, 4'd1, 0, 0);
    drive(0, 0, 0, 1, 0, 3, 0, 4'd1, 4'd14, 1, 1);
    drive(0, 0, 0, 0, 0, 3, 0, 4'd1, 4'd14, 0, 0);

    // saturate mode, including re-saturation at the limits
    drive(1, 14, 1, 0, 0, 3, 1, 4'd14, 4'd1, 0, 0);
    drive(0, 0, 0, 1, 0, 3, 1, 4'd15, 4'd0, 1, 1);
    drive(0, 0, 0, 1, 0, 3, 1, 4'd15, 4'd0, 1, 1);
    drive(0, 0, 0, 0, 0, 3, 1, 4'd15, 4'd0, 0, 0);

    // load beats swap; swap; swap without enable holds
    drive(1, 5, 9, 0, 0, 0, 0, 4'd5, 4'd9, 0, 0);
    drive(1, 5, 9, 1, 1, 0, 0, 4'd5, 4'd9, 0, 0);
    drive(0, 0, 0, 1, 1, 0, 0, 4'd9, 4'd5, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0, 4'd9, 4'd5, 0, 0);

    // step 0 counts hold with no flags
    drive(0, 0, 0, 1, 0, 0, 1, 4'd9, 4'd5, 0, 0);

    // equality
    drive(1, 7, 7, 0, 0, 1, 0, 4'd7, 4'd7, 0, 0);
    drive(0, 0, 0, 1, 0, 1, 0, 4'd8, 4'd6, 0, 0);

    // async reset mid-operation with flags high
    drive(1, 14, 1, 0, 0, 3, 0, 4'd14, 4'd1, 0, 0);
    drive(0, 0, 0, 1, 0, 3, 0, 4'd1, 4'd14, 1, 1);
    @(negedge clock);
    #3 reset_n = 1'b0;
    #1 direct("async_reset", 4'd0, 4'd15);
    enable = 1'b0;
    @(negedge clock);
    #1 direct("reset_held", 4'd0, 4'd15);
    reset_n = 1'b1;
    drive(0, 0, 0, 1, 0, 1, 0, 4'd1, 4'd14, 0, 0);
    drive(0, 0, 0, 1, 0, 1, 0, 4'd2, 4'd13, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 4'd2, 4'd13, 0, 0);

    repeat (4) @(negedge clock);
    #1;
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
